chip8_fb_engine: RTL and testbench

//  Parametrised framebuffer and sprite-draw engine for the CHIP-8/SCHIP core; replaces per-row CPU-driven display updates.

---
 rtl/chip8_fb_engine.sv | 125 ++++++++++++
 tb/tb_chip8_fb_engine.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/chip8_fb_engine.sv
// Framebuffer and sprite-draw engine for the CHIP-8/SCHIP core.
// Executes DRAW, CLEAR and SCROLL_DOWN commands and fetches sprite bytes from memory itself.
module chip8_fb_engine #(
    parameter int FB_W      = 64,
    parameter int FB_H      = 32,
    parameter int ADDR_W    = 12,
    parameter int WRAP_MODE = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [7:0]           cmd_x_i,
    input  logic [7:0]           cmd_y_i,
    input  logic [3:0]           cmd_n_i,
    input  logic [ADDR_W-1:0]    cmd_base_i,
    output logic                 mem_rd_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    input  logic [7:0]           mem_rdata_i,
    output logic                 done_o,
    output logic                 collision_o,
    output logic [FB_W*FB_H-1:0] display_o
);
    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ROW, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x0_q, x0_d;
    logic [YW-1:0]         y0_q, y0_d;
    logic [3:0]            n_q, n_d;
    logic [3:0]            row_q, row_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  coll_q, coll_d;
    logic [FB_W*FB_H-1:0]  disp_q, disp_d;

    logic [8:0]            px, py;
    logic [XW+YW-1:0]      idx;
    logic                  vis;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            n_q     <= '0;
            row_q   <= '0;
            base_q  <= '0;
            coll_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            n_q     <= n_d;
            row_q   <= row_d;
            base_q  <= base_d;
            coll_q  <= coll_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        n_d     = n_q;
        row_d   = row_q;
        base_d  = base_q;
        coll_d  = coll_q;
        disp_d  = disp_q;
        px      = '0;
        py      = '0;
        idx     = '0;
        vis     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    x0_d    = cmd_x_i[XW-1:0];
                    y0_d    = cmd_y_i[YW-1:0];
                    n_d     = cmd_n_i;
                    base_d  = cmd_base_i;
                    row_d   = '0;
                    coll_d  = 1'b0;
                    state_d = S_DONE;
                    case (cmd_op_i)
                        2'b00:   if (cmd_n_i != 4'd0) state_d = S_FETCH;
                        2'b01:   disp_d = '0;
                        // Row r lives at bits r*FB_W.., so moving rows down is a left shift.
                        2'b10:   disp_d = disp_q << (int'(cmd_n_i) * FB_W);
                        default: ;
                    endcase
                end
            end
            S_FETCH: state_d = S_ROW;
            S_ROW: begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_rdata_i[3'(7 - b)]) begin
                        px  = 9'(x0_q) + 9'(b);
                        py  = 9'(y0_q) + 9'(row_q);
                        vis = (WRAP_MODE != 0) || (px < 9'(FB_W) && py < 9'(FB_H));
                        idx = {py[YW-1:0], px[XW-1:0]};
                        if (vis) begin
                            if (disp_d[idx]) coll_d = 1'b1;
                            disp_d[idx] = ~disp_d[idx];
                        end
                    end
                end
                row_d   = row_q + 4'd1;
                state_d = (row_q == n_q - 4'd1) ? S_DONE : S_FETCH;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign mem_rd_o    = (state_q == S_FETCH);
    assign mem_addr_o  = (state_q == S_FETCH) ? base_q + ADDR_W'(row_q) : '0;
    assign done_o      = (state_q == S_DONE);
    assign collision_o = coll_q;
    assign display_o   = disp_q;
endmodule

// File: tb/tb_chip8_fb_engine.sv
// Directed bench for chip8_fb_engine: a clip-mode and a wrap-mode instance run the same command table.
module tb_chip8_fb_engine;
    localparam int FB_W = 64, FB_H = 32, ADDR_W = 12;

    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_x = '0, cmd_y = '0;
    logic [3:0] cmd_n = '0;
    logic [ADDR_W-1:0] cmd_base = '0;

    logic rdy0, rd0, done0, coll0, rdy1, rd1, done1, coll1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [7:0] rdata0 = '0, rdata1 = '0;
    logic [FB_W*FB_H-1:0] disp0, disp1;
    logic [7:0] mem [0:4095];

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    chip8_fb_engine #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .WRAP_MODE(0)) u_clip (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy0),
        .cmd_op_i(cmd_op), .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .cmd_n_i(cmd_n),
        .cmd_base_i(cmd_base), .mem_rd_o(rd0), .mem_addr_o(addr0), .mem_rdata_i(rdata0),
        .done_o(done0), .collision_o(coll0), .display_o(disp0));

    chip8_fb_engine #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .WRAP_MODE(1)) u_wrap (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy1),
        .cmd_op_i(cmd_op), .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .cmd_n_i(cmd_n),
        .cmd_base_i(cmd_base), .mem_rd_o(rd1), .mem_addr_o(addr1), .mem_rdata_i(rdata1),
        .done_o(done1), .collision_o(coll1), .display_o(disp1));

    // Synchronous read memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd0) rdata0 <= mem[addr0];
        if (rd1) rdata1 <= mem[addr1];
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  x, y;
        logic [3:0]  n;
        logic [11:0] base;
        int          lat;
        logic        coll;
        int          bit_a;
        logic        va_c, va_w;
        int          bit_b;
        logic        vb_c, vb_w;
        int          pop_c, pop_w;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int guard, lat, naddr, busy_err;
        logic [ADDR_W-1:0] a_first, a_last;
        guard = 0;
        while (!rdy0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " ready_before"}, int'(rdy0), 1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_x = v.x; cmd_y = v.y; cmd_n = v.n; cmd_base = v.base;
        @(posedge clk);
        #1;
        // Scramble operands after accept; the engine must have latched them.
        cmd_valid = 1'b0; cmd_op = 2'b01; cmd_x = 8'hA5; cmd_y = 8'h5A; cmd_n = 4'hF; cmd_base = 12'hFFF;
        lat = 0; naddr = 0; busy_err = 0; a_first = '0; a_last = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (rd0) begin
                if (naddr == 0) a_first = addr0;
                a_last = addr0;
                naddr++;
            end
            if (rdy0 || rdy1) busy_err++;
            if (done0) break;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " wrap_done_aligned"}, int'(done1), 1);
        chk({tag, " ready_low_busy"}, busy_err, 0);
        chk({tag, " coll_clip"}, int'(coll0), int'(v.coll));
        chk({tag, " coll_wrap"}, int'(coll1), int'(v.coll));
        chk({tag, " fetch_count"}, naddr, (v.op == 2'b00) ? int'(v.n) : 0);
        if (v.op == 2'b00 && v.n != 0) begin
            chk({tag, " addr_first"}, int'(a_first), int'(v.base));
            chk({tag, " addr_last"}, int'(a_last), int'(v.base + 12'(v.n) - 12'd1));
        end
        chk({tag, " bit_a_clip"}, int'(disp0[v.bit_a]), int'(v.va_c));
        chk({tag, " bit_a_wrap"}, int'(disp1[v.bit_a]), int'(v.va_w));
        chk({tag, " bit_b_clip"}, int'(disp0[v.bit_b]), int'(v.vb_c));
        chk({tag, " bit_b_wrap"}, int'(disp1[v.bit_b]), int'(v.vb_w));
        chk({tag, " pop_clip"}, $countones(disp0), v.pop_c);
        chk({tag, " pop_wrap"}, $countones(disp1), v.pop_w);
        @(negedge clk);
        chk({tag, " done_pulse"}, int'(done0), 0);
        chk({tag, " ready_after"}, int'(rdy0), 1);
    endtask

    initial begin
        int busy;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hF0;
        mem[12'h300] = 8'hFF;
        mem[12'h310] = 8'h80;
        mem[12'h311] = 8'h80;
        for (int i = 0; i < 4; i++) mem[12'h320 + i] = 8'hFF;

        //         op    x    y   n  base     lat coll bit_a  c  w  bit_b  c  w  popc popw
        vt[0]  = '{2'd0, 0,   0,  1, 12'h200, 3, 0,   3,    1, 1, 4,    0, 0, 4, 4};
        vt[1]  = '{2'd0, 0,   0,  1, 12'h200, 3, 1,   0,    0, 0, 3,    0, 0, 0, 0};
        vt[2]  = '{2'd0, 62,  31, 1, 12'h300, 3, 0,   2047, 1, 1, 1984, 0, 1, 2, 8};
        vt[3]  = '{2'd1, 0,   0,  0, 12'h000, 1, 0,   2047, 0, 0, 1984, 0, 0, 0, 0};
        vt[4]  = '{2'd0, 70,  40, 2, 12'h310, 5, 0,   518,  1, 1, 582,  1, 1, 2, 2};
        vt[5]  = '{2'd0, 5,   0,  1, 12'h310, 3, 0,   5,    1, 1, 518,  1, 1, 3, 3};
        vt[6]  = '{2'd2, 0,   0,  2, 12'h000, 1, 0,   133,  1, 1, 5,    0, 0, 3, 3};
        vt[7]  = '{2'd3, 0,   0,  2, 12'h000, 1, 0,   133,  1, 1, 646,  1, 1, 3, 3};
        vt[8]  = '{2'd0, 5,   2,  1, 12'h310, 3, 1,   133,  0, 0, 710,  1, 1, 2, 2};
        vt[9]  = '{2'd0, 5,   2,  0, 12'h310, 1, 0,   133,  0, 0, 646,  1, 1, 2, 2};
        vt[10] = '{2'd2, 0,   0,  15, 12'h000, 1, 0,  1606, 1, 1, 1670, 1, 1, 2, 2};
        vt[11] = '{2'd2, 0,   0,  8, 12'h000, 1, 0,   1606, 0, 0, 1670, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset ready", int'(rdy0), 1);
        chk("reset mem_rd", int'(rd0), 0);
        chk("reset mem_addr", int'(addr0), 0);
        chk("reset done", int'(done0), 0);
        chk("reset collision", int'(coll0), 0);
        chk("reset display", $countones(disp0) + $countones(disp1), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run(vt[i], $sformatf("vec%0d", i));

        // Reset during the second row of a 4-row draw.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x = 0; cmd_y = 0; cmd_n = 4; cmd_base = 12'h320;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset row0 drawn", $countones(disp0), 8);
        chk("midreset in row", int'(rd0), 0);
        reset = 1'b1;
        #1;
        chk("midreset display", $countones(disp0) + $countones(disp1), 0);
        chk("midreset ready", int'(rdy0), 1);
        chk("midreset mem_rd", int'(rd0), 0);
        chk("midreset collision", int'(coll0), 0);
        @(negedge clk);
        reset = 1'b0;
        busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0 || done1 || rd0) busy++;
        end
        chk("midreset no done", busy, 0);
        run(vt[0], "postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
